// File: rtl/sb_uart_rx_str.sv
// UART 8N1 string receiver: collects up to 16 bytes into a right-aligned 128-bit string.
// A message ends on the terminator byte, on a line-idle timeout, or on the 16th byte.
module sb_uart_rx_str #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] TERM         = 8'h23,
  parameter int         IDLE_BITS    = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  output logic [127:0] str,
  output logic [7:0]   str_len,
  output logic         done,
  output logic         busy,
  output logic         frame_err
);

  localparam logic [2:0] S_WAIT_HIGH = 3'd0;
  localparam logic [2:0] S_IDLE      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;

  localparam int IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
  localparam int BW       = $clog2(CLKS_PER_BIT);
  localparam int IW       = $clog2(IDLE_LIM);

  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_LIM - 1);

  logic          rx_m, rx_s;
  logic [2:0]    state;
  logic [BW-1:0] bit_cnt;
  logic [IW-1:0] idle_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [127:0]  buf_q, buf_nxt;
  logic [4:0]    cnt, cnt_nxt;

  logic bit_tick, half_tick, stop_ok, stop_bad, is_term, byte_store, idle_to, finish;

  always_comb begin
    bit_tick   = (bit_cnt == BIT_LAST);
    half_tick  = (bit_cnt == HALF_LAST);
    stop_ok    = (state == S_STOP) && bit_tick && rx_s;
    stop_bad   = (state == S_STOP) && bit_tick && !rx_s;
    is_term    = (shreg == TERM);
    byte_store = stop_ok && !is_term;
    idle_to    = (state == S_IDLE) && rx_s && (cnt != 5'd0) && (idle_cnt == IDLE_LAST);
    // A byte shifted in on the finishing cycle is part of the reported string.
    finish     = (stop_ok && is_term && (cnt != 5'd0)) ||
                 (byte_store && (cnt == 5'd15)) || idle_to;
    buf_nxt    = byte_store ? {buf_q[119:0], shreg} : buf_q;
    cnt_nxt    = byte_store ? cnt + 5'd1 : cnt;
  end

  assign busy = (cnt != 5'd0) || (state == S_START) || (state == S_DATA) || (state == S_STOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_WAIT_HIGH;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      buf_q     <= '0;
      cnt       <= '0;
      str       <= '0;
      str_len   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      done      <= finish;
      frame_err <= stop_bad;
      if (finish) begin
        str     <= buf_nxt;
        str_len <= {3'b000, cnt_nxt};
        buf_q   <= '0;
        cnt     <= '0;
      end else begin
        buf_q   <= buf_nxt;
        cnt     <= cnt_nxt;
      end

      case (state)
        S_WAIT_HIGH: if (rx_s) state <= S_IDLE;
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            bit_cnt  <= '0;
            idle_cnt <= '0;
          end else if ((cnt != 5'd0) && !idle_to) begin
            idle_cnt <= idle_cnt + IW'(1);
          end else begin
            idle_cnt <= '0;
          end
        end
        S_START: begin
          if (half_tick) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        S_STOP: begin
          // A low stop bit parks in WAIT_HIGH so a stuck-low line cannot start a frame.
          if (bit_tick) begin
            bit_cnt <= '0;
            state   <= rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: state <= S_WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_uart_rx_str.sv
// Bench for sb_uart_rx_str: directed scenarios plus random messages scored against
// a byte-stream message model.
module tb_sb_uart_rx_str;
  localparam int         CPB       = 8;
  localparam int         IDLE_BITS = 20;
  localparam logic [7:0] TERM      = 8'h23;
  localparam int         IDLE_LIM  = IDLE_BITS * CPB;
  // Edges from driving a start bit to the stop-bit sample: 2 sync + 1 detect, half bit, 9 bits.
  localparam int         STOP_OFS  = 3 + CPB / 2 + 9 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx  = 1'b1;
  logic [127:0] str;
  logic [7:0]   str_len;
  logic         done, busy, frame_err;

  sb_uart_rx_str #(.CLKS_PER_BIT(CPB), .TERM(TERM), .IDLE_BITS(IDLE_BITS)) dut (
    .clk(clk), .rst(rst), .rx(rx), .str(str), .str_len(str_len),
    .done(done), .busy(busy), .frame_err(frame_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [135:0] exp_q[$];
  logic [7:0]   msg_q[$];
  int total = 0, bad = 0;
  int done_seen = 0, fe_seen = 0, last_done_cyc = -1, last_start_cyc = 0;

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done || frame_err) check("done_fe_exclusive", 136'(done && frame_err), 136'd0);
      if (done) begin
        done_seen++;
        last_done_cyc = cyc;
        check("done_expected", 136'(done), 136'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("msg", {str_len, str}, exp_q.pop_front());
      end
      if (frame_err) fe_seen++;
    end
  end

  // reference model: split a byte stream into messages by the terminator / 16-byte rules
  task automatic model_push(input bit idle_end);
    logic [127:0] acc;
    int n;
    acc = '0;
    n = 0;
    foreach (msg_q[i]) begin
      if (msg_q[i] == TERM) begin
        if (n > 0) exp_q.push_back({8'(n), acc});
        acc = '0;
        n = 0;
      end else begin
        acc = acc * 256 + 128'(msg_q[i]);
        n++;
        if (n == 16) begin
          exp_q.push_back({8'(n), acc});
          acc = '0;
          n = 0;
        end
      end
    end
    if (idle_end && n > 0) exp_q.push_back({8'(n), acc});
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_msg(input int gap_max);
    foreach (msg_q[i]) begin
      send_byte(msg_q[i], 1'b1);
      if (gap_max > 0) tick($urandom_range(0, gap_max));
    end
  endtask

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(8'(s[i]));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 136'(exp_q.size()), 136'd0);
  endtask

  int d0, f0, s_exp, k, len;
  logic [7:0] b, yb;
  bit idle_end;

  initial begin
    tick(3);
    rst = 1'b0;
    tick(3);
    check("rst_str", 136'(str), 136'd0);
    check("rst_len", 136'(str_len), 136'd0);
    check("rst_done", 136'(done), 136'd0);
    check("rst_busy", 136'(busy), 136'd0);
    check("rst_fe", 136'(frame_err), 136'd0);

    // "HI#"
    d0 = done_seen;
    load_str("HI#");
    model_push(1'b0);
    send_msg(0);
    tick(4);
    wait_drain("hi_drain", 50);
    check("hi_done_count", 136'(done_seen - d0), 136'd1);
    check("hi_busy_after", 136'(busy), 136'd0);

    // 17 bytes 0x41..0x51 then terminator
    msg_q.delete();
    for (int i = 0; i < 17; i++) msg_q.push_back(8'(8'h41 + i));
    msg_q.push_back(TERM);
    d0 = done_seen;
    model_push(1'b0);
    send_msg(0);
    tick(4);
    wait_drain("long_drain", 50);
    check("long_done_count", 136'(done_seen - d0), 136'd2);

    // "AB" then idle timeout
    d0 = done_seen;
    load_str("AB");
    model_push(1'b1);
    send_msg(0);
    s_exp = last_start_cyc + STOP_OFS + IDLE_LIM;
    check("idle_busy_hold", 136'(busy), 136'd1);
    k = 0;
    while (done_seen == d0 && k < IDLE_LIM + 50) begin
      tick(1);
      k++;
    end
    check("idle_done_cycle", 136'(last_done_cyc), 136'(s_exp));
    wait_drain("idle_drain", 10);

    // glitch, then framing error, then recovery
    d0 = done_seen;
    f0 = fe_seen;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * CPB);
    check("glitch_done", 136'(done_seen - d0), 136'd0);
    check("glitch_fe", 136'(fe_seen - f0), 136'd0);
    check("glitch_busy", 136'(busy), 136'd0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rx = 1'b1;
    tick(2 * CPB);
    check("ferr_pulse", 136'(fe_seen - f0), 136'd1);
    check("ferr_no_done", 136'(done_seen - d0), 136'd0);
    load_str("Z#");
    model_push(1'b0);
    send_msg(0);
    tick(4);
    wait_drain("ferr_drain", 50);
    check("ferr_done_count", 136'(done_seen - d0), 136'd1);

    // reset during data bit 4 of the second byte
    d0 = done_seen;
    load_str("X");
    send_msg(0);
    yb = 8'h59;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) send_bit(yb[i]);
    rx = yb[4];
    tick(CPB / 2);
    check("abort_busy_mid", 136'(busy), 136'd1);
    rst = 1'b1;
    #1;
    check("abort_str", 136'(str), 136'd0);
    check("abort_len", 136'(str_len), 136'd0);
    check("abort_busy", 136'(busy), 136'd0);
    check("abort_done", 136'(done), 136'd0);
    check("abort_fe", 136'(frame_err), 136'd0);
    rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(IDLE_LIM + 10);
    check("abort_no_done", 136'(done_seen - d0), 136'd0);
    load_str("XY#");
    model_push(1'b0);
    send_msg(0);
    tick(4);
    wait_drain("abort_drain", 50);

    // lone terminator, then back-to-back "OK#"
    d0 = done_seen;
    load_str("#");
    send_msg(0);
    tick(4);
    check("term_only_done", 136'(done_seen - d0), 136'd0);
    check("term_only_busy", 136'(busy), 136'd0);
    load_str("OK#");
    model_push(1'b0);
    send_msg(0);
    tick(4);
    wait_drain("ok_drain", 50);

    // random messages
    for (int m = 0; m < 6; m++) begin
      len = $urandom_range(1, 20);
      msg_q.delete();
      for (int j = 0; j < len; j++) begin
        do b = 8'($urandom_range(32, 126)); while (b == TERM);
        msg_q.push_back(b);
      end
      idle_end = 1'($urandom_range(0, 1));
      if (!idle_end) msg_q.push_back(TERM);
      model_push(idle_end);
      send_msg(3 * CPB);
      tick(idle_end ? IDLE_LIM + 2 * CPB : 2 * CPB);
    end
    wait_drain("rand_drain", 2 * IDLE_LIM);
    check("fe_total", 136'(fe_seen), 136'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
